seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed N-digit 7-segment driver. BCD digits go in and are decoded to segment patterns
//   (a..g, active-low). One digit is strobed at a time, with an anti-ghosting blank gap between slots.
//   Inputs are snapshotted once per frame so the display never tears. Sits between the time/counter
//   logic and the board's common-anode display pins.
// PARAMETERS
//   NUM_DIGITS    6      digits driven (>=1); digit 0 = least significant
//   SCAN_DIV      50000  clk cycles per digit slot (>=2)
//   BLANK_CYCLES  4      leading cycles of each slot with all anodes off (< SCAN_DIV)
// PORTS
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             asynchronous reset, active low
//   en           in   1             1 = scan running; 0 = display dark, scan frozen
//   bcd_in       in   4*NUM_DIGITS  digit i = bcd_in[4i+3:4i]
//   dp_in        in   NUM_DIGITS    decimal point per digit, 1 = lit
//   seg          out  7             {a,b,c,d,e,f,g}, 0 = segment lit
//   dp           out  1             decimal point, 0 = lit
//   an           out  NUM_DIGITS    anode enables, 0 = digit on, at most one bit low
//   frame_start  out  1             1-cycle pulse, first cycle after a snapshot
// BEHAVIOUR
//   - State: cnt (0..SCAN_DIV-1), idx (0..NUM_DIGITS-1), shadow_bcd, shadow_dp.
//   - Advance: cnt increments on each cycle with en=1. At SCAN_DIV-1, cnt wraps to 0 and idx increments;
//     idx wraps NUM_DIGITS-1 -> 0. Frame period = NUM_DIGITS*SCAN_DIV cycles.
//   - Snapshot: on an en=1 cycle with idx==0 and cnt==0, shadow <= {bcd_in, dp_in}.
//     frame_start=1 on the next cycle only. Input changes at any other time have no visible effect until
//     the next snapshot.
//   - Decode: 0..9 -> 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100.
//     Codes A..F -> 1111111 (blank).
//   - All outputs are registered. One cycle latency from state (idx,cnt,shadow,en) to pins.
//   - Slot output, driven for cnt>=BLANK_CYCLES with en=1: an = ~(1<<idx), seg = decode(shadow digit idx),
//     dp = ~shadow_dp[idx].
//   - Blank output, driven for cnt<BLANK_CYCLES or en=0: an = all 1, seg = 7'h7F, dp = 1.
//   - en=0 mid-slot: pins go dark on the next edge. cnt/idx/shadow hold. en=1 resumes at the held
//     cnt/idx; no re-snapshot unless the resume point is idx==0, cnt==0.
//   - Reset (async assert, any time incl. mid-frame): cnt=0, idx=0, shadow_bcd = all 4'hF, shadow_dp = 0,
//     seg=7'h7F, dp=1, an = all 1, frame_start=0.
//     The first en=1 cycle after release is a snapshot cycle.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - At snapshot, any shadow digit of value 0 that lies above the most significant nonzero digit is
//       stored as 4'hF (blank).
//     - Digit 0 is never suppressed, so all-zero input shows a single "0".
//     - dp_in is unaffected.
//   LEADING_ZERO_BLANK_EN undefined: all digits are displayed as given.
// STRUCTURE
//   - Package seg7_pkg: SEG_BLANK=7'h7F, BCD_BLANK=4'hF, segment constants SEG_0..SEG_9,
//     function/typedef for the 7-bit segment vector.
//   - Sub-module seg7_bcd_lut: combinational 4-bit BCD -> 7-bit active-low segments. One instance on the
//     selected shadow digit.
//   - Top: prescaler, digit index, snapshot/LZ logic, output registers.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
//   1. rst_n=0 with en=1, bcd_in=16'h1234 -> seg=7'h7F, dp=1, an=4'hF, frame_start=0, held throughout reset.
//   2. Release with en=1, bcd_in=16'h1234:
//      - frame_start pulses every 32 cycles.
//      - an cycles 1110,1101,1011,0111; each is low 6 cycles after 2 dark cycles.
//      - seg per slot: 1001100, 0000110, 0010010, 1001111.
//   3. bcd_in 16'h1234 -> 16'h9876 during slot 2 -> slots 2,3 still show 2,1; next frame shows
//      0000100, 0001111, 0100000, 0000000.
//   4. bcd_in=16'hA0B5, dp_in=4'b0100 ->
//      - digits 1 and 3 show 7'h7F; digit 0 shows 0100100; digit 2 shows 0000001 with dp=0.
//      - dp=1 elsewhere.
//   5. Timing edge cases:
//      - en=0 at cnt=5 of slot 1 -> an=4'hF next edge; cnt/idx frozen.
//      - en=1 after 20 cycles -> slot 1 resumes at cnt=5.
//      - rst_n pulse mid-slot -> immediate blank outputs, then restart at idx 0 with snapshot.
//   6. With LEADING_ZERO_BLANK_EN:
//      - 16'h0005 -> digits 3..1 = 7'h7F, digit 0 = 0100100.
//      - 16'h0000 -> only digit 0 = 0000001.
//      - 16'h0105 -> digit 3 blank, digit 2 = 1001111, digit 1 = 0000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment vector type, blank codes and BCD decode shared by the scan driver.
package seg7_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam seg_t       SEG_0     = 7'b0000001;
    localparam seg_t       SEG_1     = 7'b1001111;
    localparam seg_t       SEG_2     = 7'b0010010;
    localparam seg_t       SEG_3     = 7'b0000110;
    localparam seg_t       SEG_4     = 7'b1001100;
    localparam seg_t       SEG_5     = 7'b0100100;
    localparam seg_t       SEG_6     = 7'b0100000;
    localparam seg_t       SEG_7     = 7'b0001111;
    localparam seg_t       SEG_8     = 7'b0000000;
    localparam seg_t       SEG_9     = 7'b0000100;

    // Codes A..F render as a dark digit.
    function automatic seg_t bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/seg7_bcd_lut.sv
// seg7_bcd_lut: combinational BCD digit to active-low {a..g} segment pattern.
module seg7_bcd_lut
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg_t       o_seg
);
    assign o_seg = bcd_to_seg(i_bcd);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with per-frame input snapshot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits at snapshot time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_start;

    logic                    w_cnt_last;
    logic                    w_idx_last;
    logic                    w_snap;
    logic                    w_slot;
    logic [3:0]              w_digit;
    seg_t                    w_seg;
    logic [NUM_DIGITS-1:0]   w_an_on;
    logic [4*NUM_DIGITS-1:0] w_snap_bcd;

    assign w_cnt_last = r_cnt == CW'(SCAN_DIV - 1);
    assign w_idx_last = r_idx == IW'(NUM_DIGITS - 1);
    assign w_snap     = en && r_idx == '0 && r_cnt == '0;
    assign w_slot     = en && r_cnt >= CW'(BLANK_CYCLES);
    assign w_digit    = r_shadow_bcd[{r_idx, 2'b00} +: 4];
    assign w_an_on    = ~(NUM_DIGITS'(1) << r_idx);

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; zeros stay blank until the first nonzero code. Digit 0 always shows.
    always_comb begin
        logic w_lead;
        w_snap_bcd = bcd_in;
        w_lead     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lead = w_lead && bcd_in[4*i +: 4] == 4'd0;
            if (w_lead) w_snap_bcd[4*i +: 4] = BCD_BLANK;
        end
    end
`else
    assign w_snap_bcd = bcd_in;
`endif

    seg7_bcd_lut u_lut (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow_bcd  <= {NUM_DIGITS{BCD_BLANK}};
            r_shadow_dp   <= '0;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_an          <= '1;
            r_frame_start <= 1'b0;
        end else begin
            if (en) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                if (w_cnt_last) r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end
            if (w_snap) begin
                r_shadow_bcd <= w_snap_bcd;
                r_shadow_dp  <= dp_in;
            end
            r_frame_start <= w_snap;
            r_an          <= w_slot ? w_an_on : '1;
            r_seg         <= w_slot ? w_seg : SEG_BLANK;
            r_dp          <= w_slot ? ~r_shadow_dp[r_idx] : 1'b1;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, snapshot, decode, pause and reset (4 digits, div 8, blank 2).
module tb_seg7_scan_driver;
    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b1;
    logic [15:0] bcd_in = 16'h1234;
    logic [3:0]  dp_in  = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    logic [12:0] obs;
    int          checks = 0;
    int          errors = 0;
    int          k      = 0;

    always #5 clk = ~clk;
    assign obs = {frame_start, an, seg, dp};

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 13'b0_1111_1111111_1) begin
                errors++;
                $display("FAIL reset i=%0d got {fs,an,seg,dp}=%b exp %b", i, obs, 13'b0_1111_1111111_1);
            end
        end
        rst_n = 1'b1;
        k     = -1;
    endtask

    task automatic test_scan;
        logic [6:0]  tab [4];
        logic [12:0] exp;
        logic        on;
        int          d;
        tab = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        for (int i = 0; i <= 32; i++) begin
            tick;
            d   = (k / 8) % 4;
            on  = (k % 8) >= 2;
            exp = {(k % 32) == 0, on ? ~(4'b0001 << d) : 4'hF, on ? tab[d] : 7'h7F, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL scan k=%0d got {fs,an,seg,dp}=%b exp %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_snapshot;
        logic [6:0]  t_old [4];
        logic [6:0]  t_new [4];
        logic [12:0] exp;
        logic        on;
        int          d;
        t_old = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        t_new = '{7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        while (k < 49) tick;
        bcd_in = 16'h9876;
        while (k < 95) begin
            tick;
            d   = (k / 8) % 4;
            on  = (k % 8) >= 2;
            exp = {(k % 32) == 0, on ? ~(4'b0001 << d) : 4'hF,
                   on ? (k < 64 ? t_old[d] : t_new[d]) : 7'h7F, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL snapshot k=%0d got {fs,an,seg,dp}=%b exp %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_blank_codes;
        logic [6:0]  tab [4];
        logic [12:0] exp;
        logic        on;
        int          d;
        tab    = '{7'b0100100, 7'h7F, 7'b0000001, 7'h7F};
        bcd_in = 16'hA0B5;
        dp_in  = 4'b0100;
        while (k < 127) begin
            tick;
            d   = (k / 8) % 4;
            on  = (k % 8) >= 2;
            exp = {(k % 32) == 0, on ? ~(4'b0001 << d) : 4'hF, on ? tab[d] : 7'h7F, !(on && d == 2)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL blank_codes k=%0d got {fs,an,seg,dp}=%b exp %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_en_pause;
        logic [12:0] exp;
        while (k < 140) tick;
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++;
            if (obs !== 13'b0_1111_1111111_1) begin
                errors++;
                $display("FAIL pause i=%0d got {fs,an,seg,dp}=%b exp %b", i, obs, 13'b0_1111_1111111_1);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            exp = i < 3 ? 13'b0_1101_1111111_1 : i < 5 ? 13'b0_1111_1111111_1 : 13'b0_1011_0000001_0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL resume i=%0d got {fs,an,seg,dp}=%b exp %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [12:0] exp;
        logic        on;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'b0_1111_1111111_1) begin
            errors++;
            $display("FAIL reset_async got {fs,an,seg,dp}=%b exp %b", obs, 13'b0_1111_1111111_1);
        end
        @(negedge clk);
        checks++;
        if (obs !== 13'b0_1111_1111111_1) begin
            errors++;
            $display("FAIL reset_hold got {fs,an,seg,dp}=%b exp %b", obs, 13'b0_1111_1111111_1);
        end
        bcd_in = 16'h4321;
        dp_in  = 4'b0000;
        rst_n  = 1'b1;
        k      = -1;
        for (int i = 0; i < 8; i++) begin
            tick;
            on  = (k % 8) >= 2;
            exp = {k == 0, on ? 4'b1110 : 4'hF, on ? 7'b1001111 : 7'h7F, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL restart k=%0d got {fs,an,seg,dp}=%b exp %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [15:0] vec [3];
        logic [6:0]  ex [3][4];
        logic [12:0] exp;
        int          d;
        vec = '{16'h0005, 16'h0000, 16'h0105};
`ifdef LEADING_ZERO_BLANK_EN
        ex = '{'{7'b0100100, 7'h7F, 7'h7F, 7'h7F},
               '{7'b0000001, 7'h7F, 7'h7F, 7'h7F},
               '{7'b0100100, 7'b0000001, 7'b1001111, 7'h7F}};
`else
        ex = '{'{7'b0100100, 7'b0000001, 7'b0000001, 7'b0000001},
               '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001},
               '{7'b0100100, 7'b0000001, 7'b1001111, 7'b0000001}};
`endif
        for (int v = 0; v < 3; v++) begin
            while ((k % 32) != 31) tick;
            bcd_in = vec[v];
            for (int i = 0; i < 32; i++) begin
                tick;
                if ((k % 8) == 4) begin
                    d   = (k / 8) % 4;
                    exp = {1'b0, ~(4'b0001 << d), ex[v][d], 1'b1};
                    checks++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL leading_zero v=%0d digit=%0d got {fs,an,seg,dp}=%b exp %b", v, d, obs, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_blank_codes;
        test_en_pause;
        test_reset_mid;
        test_leading_zero;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
